// File: rtl/cpu_muldiv_if.sv
// cpu_muldiv_if: request/response bundle between the pipeline and the
// RV32M multiply/divide unit. The master issues requests; the slave is the unit.
interface cpu_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        kill;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  modport master (output start, op, src_a, src_b, kill, input busy, valid, result);
  modport slave  (input start, op, src_a, src_b, kill, output busy, valid, result);
endinterface

// File: rtl/cpu_muldiv.sv
// cpu_muldiv: iterative RV32M multiply/divide unit, one bit per cycle.
// Multiply is shift-add over a 64-bit accumulator; divide is restoring
// shift-subtract. Operands are made non-negative on accept and the sign is
// fixed up when the result register is loaded.
// Build option: define MULDIV_DIV_EN to include the divide datapath; without
// it, ops 4-7 complete one cycle after accept with a zero result.
module cpu_muldiv (
  input logic         clk,
  input logic         rst,
  cpu_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, acc_init, step;
  logic [31:0] opnd_q, opnd_init;
  logic [31:0] result_q, result_d, final_res;
  logic        hi_q, neg_q;
  logic        accept;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] prod;
`ifdef MULDIV_DIV_EN
  logic        is_div_q, is_rem_q, rem_neg_q;
  logic [33:0] div_diff;
  logic [31:0] quo, rem;
`endif

  assign accept = (state_q == IDLE) && bus.start && !bus.kill;

  // MULH, MULHSU, DIV and REM read rs1 as signed; MULH, DIV and REM also rs2.
  assign a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign a_neg    = a_signed && bus.src_a[31];
  assign b_neg    = b_signed && bus.src_b[31];
  assign abs_a    = a_neg ? (32'd0 - bus.src_a) : bus.src_a;
  assign abs_b    = b_neg ? (32'd0 - bus.src_b) : bus.src_b;

`ifdef MULDIV_DIV_EN
  // Divide keeps the dividend in the accumulator and the divisor aside.
  assign acc_init  = bus.op[2] ? {32'd0, abs_a} : {32'd0, abs_b};
  assign opnd_init = bus.op[2] ? abs_b : abs_a;
`else
  assign acc_init  = {32'd0, abs_b};
  assign opnd_init = abs_a;
`endif

  // One iteration of the active algorithm applied to the accumulator.
  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    step    = {mul_sum, acc_q[31:1]};
`ifdef MULDIV_DIV_EN
    // Partial remainder shifted left with the next dividend bit: 33 bits wide.
    div_diff = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};
    if (is_div_q) begin
      if (div_diff[33]) step = {acc_q[62:0], 1'b0};
      else              step = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
`endif
  end

  // Sign correction and selection of the architectural result.
  always_comb begin
    prod      = neg_q ? (64'd0 - step) : step;
    final_res = hi_q ? prod[63:32] : prod[31:0];
`ifdef MULDIV_DIV_EN
    quo = neg_q ? (32'd0 - step[31:0]) : step[31:0];
    rem = rem_neg_q ? (32'd0 - step[63:32]) : step[63:32];
    if (is_div_q) final_res = is_rem_q ? rem : quo;
`endif
  end

  // Next-state, counter, accumulator and result-register control.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = 6'd0;
          acc_d = acc_init;
`ifdef MULDIV_DIV_EN
          state_d = CALC;
`else
          if (bus.op[2]) begin
            state_d  = DONE;
            result_d = 32'd0;
          end else begin
            state_d = CALC;
          end
`endif
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          result_d = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush wins over everything and leaves the result register untouched.
    if (bus.kill) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // State, counter, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Operand and sign information captured when a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_q    <= 32'd0;
      hi_q      <= 1'b0;
      neg_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else if (accept) begin
      opnd_q    <= opnd_init;
      hi_q      <= (bus.op[1:0] != 2'd0);
      // A zero divisor keeps the all-ones quotient unnegated.
      neg_q     <= (a_neg ^ b_neg) && (bus.src_b != 32'd0);
`ifdef MULDIV_DIV_EN
      is_div_q  <= bus.op[2];
      is_rem_q  <= bus.op[1];
      rem_neg_q <= a_neg;
`endif
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.valid  = (state_q == DONE) && !bus.kill;
  assign bus.result = result_q;

endmodule
